// File: rtl/key_entry_ctrl.sv
// key_entry_ctrl: turns keypad key events into multi-digit BCD entries.
// Digits are collected MSB-first, with backspace and clear. ENTER hands the
// completed entry to a valid/ready consumer.
// Optional build macro: KEY_ENTRY_TIMEOUT_EN adds an idle timeout that
// discards a partial entry after TIMEOUT_CYC quiet cycles.
module key_entry_ctrl #(
  parameter int unsigned DIGITS      = 4,
  parameter logic [3:0]  KEY_BKSP    = 4'd10,
  parameter logic [3:0]  KEY_CLR     = 4'd11,
  parameter logic [3:0]  KEY_ENTER   = 4'd14,
  parameter int unsigned TIMEOUT_CYC = 250_000_000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  key_flag,
  input  logic [3:0]            key_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DIGITS*4-1:0]   out_value,
  output logic [3:0]            out_len,
  output logic [3:0]            cur_len,
  output logic                  busy,
  output logic                  err
);

  localparam int unsigned W        = DIGITS * 4;
  localparam logic [3:0]  DIGITS_L = 4'(DIGITS);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ENTRY = 2'd1,
    HOLD  = 2'd2
  } state_e;

  state_e         state_q, state_d;
  logic [W-1:0]   buf_q, buf_d;
  logic [3:0]     len_q, len_d;
  logic [W-1:0]   out_value_q, out_value_d;
  logic [3:0]     out_len_q, out_len_d;
  logic           out_valid_q, out_valid_d;
  logic           err_q, err_d;
  logic           busy_q, busy_d;
  logic           is_digit;

`ifdef KEY_ENTRY_TIMEOUT_EN
  localparam logic [27:0] TO_LAST = 28'(TIMEOUT_CYC - 1);
  logic [27:0]    cnt_q, cnt_d;
`else
  // Timeout disabled: the parameter is intentionally left without a consumer.
  logic           unused_timeout;
  assign unused_timeout = ^TIMEOUT_CYC;
`endif

  assign is_digit = (key_data <= 4'd9);

  // Next-state, buffer and output-register computation for the entry FSM.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves a latch behind.
    state_d     = state_q;
    buf_d       = buf_q;
    len_d       = len_q;
    out_value_d = out_value_q;
    out_len_d   = out_len_q;
    out_valid_d = out_valid_q;
    err_d       = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (key_flag && is_digit) begin
          buf_d   = W'(key_data);
          len_d   = 4'd1;
          state_d = ENTRY;
        end
      end

      ENTRY: begin
        if (key_flag) begin
          if (is_digit) begin
            if (len_q < DIGITS_L) begin
              // Shift left one nibble; anything above W bits falls off.
              buf_d = (buf_q << 4) | W'(key_data);
              len_d = len_q + 4'd1;
            end else begin
              err_d = 1'b1;
            end
          end else if (key_data == KEY_BKSP) begin
            buf_d = buf_q >> 4;
            len_d = len_q - 4'd1;
            if (len_q == 4'd1) state_d = IDLE;
          end else if (key_data == KEY_CLR) begin
            buf_d   = '0;
            len_d   = 4'd0;
            state_d = IDLE;
          end else if (key_data == KEY_ENTER) begin
            out_value_d = buf_q;
            out_len_d   = len_q;
            out_valid_d = 1'b1;
            buf_d       = '0;
            len_d       = 4'd0;
            state_d     = HOLD;
          end
          // Remaining non-digit codes are ignored silently.
        end
`ifdef KEY_ENTRY_TIMEOUT_EN
        else if (cnt_q == TO_LAST) begin
          buf_d   = '0;
          len_d   = 4'd0;
          err_d   = 1'b1;
          state_d = IDLE;
        end
`endif
      end

      HOLD: begin
        // Keys are never queued behind a pending entry.
        if (key_flag) err_d = 1'b1;
        if (out_valid_q && out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

`ifdef KEY_ENTRY_TIMEOUT_EN
  // Idle counter: counts quiet cycles in ENTRY, zero everywhere else.
  always_comb begin
    cnt_d = 28'd0;
    if (state_q == ENTRY && state_d == ENTRY && !key_flag) cnt_d = cnt_q + 28'd1;
  end

  // Idle counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= 28'd0;
    else        cnt_q <= cnt_d;
  end
`endif

  // State and output registers; reset drops any pending entry immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: non-blocking assignments so every flop samples pre-edge values.
    if (!rst_n) begin
      state_q     <= IDLE;
      buf_q       <= '0;
      len_q       <= 4'd0;
      out_value_q <= '0;
      out_len_q   <= 4'd0;
      out_valid_q <= 1'b0;
      err_q       <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      buf_q       <= buf_d;
      len_q       <= len_d;
      out_value_q <= out_value_d;
      out_len_q   <= out_len_d;
      out_valid_q <= out_valid_d;
      err_q       <= err_d;
      busy_q      <= busy_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_value = out_value_q;
  assign out_len   = out_len_q;
  assign cur_len   = len_q;
  assign busy      = busy_q;
  assign err       = err_q;

endmodule

// File: tb/tb_key_entry_ctrl.sv
// Directed self-checking bench for key_entry_ctrl (DIGITS=4).
// Inputs change and outputs are sampled on the falling clock edge.
module tb_key_entry_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        key_flag = 1'b0;
  logic [3:0]  key_data = 4'd0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [15:0] out_value;
  logic [3:0]  out_len;
  logic [3:0]  cur_len;
  logic        busy;
  logic        err;

  int passed = 0;
  int total  = 0;

  localparam logic [3:0] BKSP  = 4'd10;
  localparam logic [3:0] CLR   = 4'd11;
  localparam logic [3:0] ENTER = 4'd14;

  key_entry_ctrl #(
    .DIGITS(4), .KEY_BKSP(BKSP), .KEY_CLR(CLR), .KEY_ENTER(ENTER), .TIMEOUT_CYC(1000)
  ) dut (
    .clk(clk), .rst_n(rst_n), .key_flag(key_flag), .key_data(key_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_value(out_value),
    .out_len(out_len), .cur_len(cur_len), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  // One-cycle key strobe; returns on the falling edge after it was captured.
  task automatic press(input logic [3:0] k);
    @(negedge clk);
    key_flag = 1'b1;
    key_data = k;
    @(negedge clk);
    key_flag = 1'b0;
    key_data = 4'd0;
  endtask

  initial begin
    // Reset state
    step();
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_value", 32'(out_value), 32'd0);
    check("rst_len",   32'(out_len),   32'd0);
    check("rst_cur",   32'(cur_len),   32'd0);
    check("rst_busy",  32'(busy),      32'd0);
    check("rst_err",   32'(err),       32'd0);
    rst_n = 1'b1;

    // 1,2,3,ENTER with ready high
    press(4'd1); press(4'd2); press(4'd3);
    check("t1_cur", 32'(cur_len), 32'd3);
    check("t1_busy", 32'(busy), 32'd1);
    press(ENTER);
    check("t1_valid", 32'(out_valid), 32'd1);
    check("t1_value", 32'(out_value), 32'h0123);
    check("t1_len",   32'(out_len),   32'd3);
    check("t1_curclr", 32'(cur_len), 32'd0);
    step();
    check("t1_valid_off", 32'(out_valid), 32'd0);
    check("t1_idle", 32'(busy), 32'd0);

    // Overflow: fifth digit rejected
    press(4'd9); press(4'd8); press(4'd7); press(4'd6);
    check("t2_err_none", 32'(err), 32'd0);
    press(4'd5);
    check("t2_err", 32'(err), 32'd1);
    check("t2_cur", 32'(cur_len), 32'd4);
    step();
    check("t2_err_pulse", 32'(err), 32'd0);
    press(ENTER);
    check("t2_value", 32'(out_value), 32'h9876);
    check("t2_len",   32'(out_len),   32'd4);
    step();

    // Backspace inside an entry
    press(4'd4); press(4'd5); press(BKSP);
    check("t3_cur_bksp", 32'(cur_len), 32'd1);
    press(4'd7); press(ENTER);
    check("t3_value", 32'(out_value), 32'h0047);
    check("t3_len",   32'(out_len),   32'd2);
    step();
    // Backspace down to empty
    press(4'd3); press(BKSP);
    check("t3_cur0", 32'(cur_len), 32'd0);
    check("t3_idle", 32'(busy), 32'd0);
    check("t3_novalid", 32'(out_valid), 32'd0);

    // Back-pressure with a key arriving in HOLD
    out_ready = 1'b0;
    press(4'd2); press(ENTER);
    check("t4_valid", 32'(out_valid), 32'd1);
    check("t4_value", 32'(out_value), 32'h0002);
    repeat (48) step();
    press(4'd5);
    check("t4_err", 32'(err), 32'd1);
    check("t4_hold_valid", 32'(out_valid), 32'd1);
    check("t4_hold_cur", 32'(cur_len), 32'd0);
    repeat (49) step();
    check("t4_err_gone", 32'(err), 32'd0);
    check("t4_stable_value", 32'(out_value), 32'h0002);
    check("t4_stable_len", 32'(out_len), 32'd1);
    check("t4_busy", 32'(busy), 32'd1);
    out_ready = 1'b1;
    step();
    check("t4_xfer_valid", 32'(out_valid), 32'd0);
    check("t4_xfer_idle", 32'(busy), 32'd0);
    press(4'd1); press(ENTER);
    check("t4_next_value", 32'(out_value), 32'h0001);
    check("t4_next_len", 32'(out_len), 32'd1);
    step();

    // Clear, then ENTER in IDLE and a stray code in IDLE
    press(4'd6); press(CLR);
    check("t5_cur", 32'(cur_len), 32'd0);
    check("t5_idle", 32'(busy), 32'd0);
    press(ENTER);
    check("t5_novalid", 32'(out_valid), 32'd0);
    press(4'd12);
    check("t5_k12_busy", 32'(busy), 32'd0);
    check("t5_k12_err", 32'(err), 32'd0);

    // Unassigned codes in ENTRY are ignored without err
    press(4'd3); press(4'd13);
    check("t5_k13_err", 32'(err), 32'd0);
    check("t5_k13_cur", 32'(cur_len), 32'd1);
    press(CLR);

`ifdef KEY_ENTRY_TIMEOUT_EN
    // Idle timeout after 1000 quiet cycles
    press(4'd8);
    repeat (999) step();
    check("t6_still_entry", 32'(busy), 32'd1);
    check("t6_still_cur", 32'(cur_len), 32'd1);
    step();
    check("t6_err", 32'(err), 32'd1);
    check("t6_cur", 32'(cur_len), 32'd0);
    check("t6_idle", 32'(busy), 32'd0);
    step();
    check("t6_err_pulse", 32'(err), 32'd0);
`endif

    // Asynchronous reset while an entry is held
    out_ready = 1'b0;
    press(4'd3); press(ENTER);
    check("t7_valid", 32'(out_valid), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("t7_rst_valid", 32'(out_valid), 32'd0);
    check("t7_rst_value", 32'(out_value), 32'd0);
    check("t7_rst_len",   32'(out_len),   32'd0);
    check("t7_rst_busy",  32'(busy),      32'd0);
    check("t7_rst_cur",   32'(cur_len),   32'd0);
    step();
    rst_n = 1'b1;
    out_ready = 1'b1;
    step();
    check("t7_after_valid", 32'(out_valid), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
